sr_ff_checker: RTL
==================

# sr_ff_checker

Synthesizable clocked checker that sits on the output side of the clocked SR flip-flop and judges its response cycle by cycle. It watches the S/R inputs applied to the flip-flop and the Q/Q̄ it returns, and keeps an internal reference model of Q. It flags mismatches, complementarity violations and forbidden S=R=1 inputs, and accumulates saturating counts so that board runs can be judged without a waveform viewer.

## Interface
Parameters:
- CNT_W, 8: width of every event counter.

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; when 0 the block holds all state and `mismatch` is 0.
- clr  input  1  synchronous clear of the model, counters and sticky flag; takes priority over `en`.
- s  input  1  S applied to the flip-flop under check.
- r  input  1  R applied to the flip-flop under check.
- q  input  1  Q returned by the flip-flop.
- qbar  input  1  Q̄ returned by the flip-flop.
- q_ref  output  1  reference-model Q.
- ref_valid  output  1  1 when `q_ref` is known (state TRACK).
- mismatch  output  1  one-cycle pulse: a check failed at the last enabled edge.
- err_sticky  output  1  set by any mismatch; cleared only by reset or `clr`.
- forbidden_cnt  output  CNT_W  number of enabled edges that sampled s=r=1.
- check_cnt  output  CNT_W  number of enabled edges on which a check was performed.
- err_cnt  output  CNT_W  number of failed checks.

## Operation
- Two-state FSM:
  - UNK: reference unknown, no checks.
  - TRACK: reference known, checks active.
- Each enabled edge does two things in order:
  - Check: uses the sampled q/qbar and the current q_ref.
  - Update: uses the sampled s/r.
- Check, performed only in TRACK. It fails if q != q_ref or qbar != ~q. A failure increments err_cnt, sets err_sticky and pulses mismatch. Every check increments check_cnt.
- Check in UNK: none performed. check_cnt and err_cnt are unchanged and mismatch is 0. The qbar complement rule is also not enforced in UNK.
- Update by sampled s/r:
  - 00: q_ref holds; state unchanged.
  - 01: q_ref := 0; go to TRACK.
  - 10: q_ref := 1; go to TRACK.
  - 11: forbidden_cnt increments; go to UNK; q_ref holds its last value but is meaningless, so ref_valid = 0.
- Counters saturate at 2^CNT_W−1 and never wrap. At saturation, err_sticky and mismatch still behave normally.
- clr with the clock:
  - Goes to UNK.
  - q_ref = 0, all counters = 0, err_sticky = 0, mismatch = 0.
  - No check or update is performed on that edge.
- en = 0: nothing changes except mismatch, which is forced to 0 on that edge.

## Timing
- Reset values (asynchronous on rst_n = 0):
  - state UNK, q_ref = 0, ref_valid = 0
  - mismatch = 0, err_sticky = 0
  - all counters = 0
- Alignment: the flip-flop captures s/r at edge n and presents Q after edge n. The checker samples that Q at edge n+1 against the q_ref it computed at edge n. Net latency is one cycle from stimulus to check.
- mismatch and counter updates are registered. They are visible in the cycle after the failing edge, and mismatch lasts exactly one cycle per failing edge.
- ref_valid rises in the cycle after the first 01 or 10 edge following reset, clr or an 11.
- The first edge after leaving UNK is checked. Example: 10 at edge n, then the check at edge n+1 expects q = 1.
- rst_n deasserted mid-sequence: the block restarts in UNK. Checks are unaffected by earlier history.
- Simultaneous clr and en=1 with s=r=1: clr wins, so forbidden_cnt = 0 afterwards.

## Test plan
- Reset, then drive s/r = 10, 00, 01, 00, one per edge, with a correct flip-flop. Required: ref_valid = 1 from cycle 2; q_ref = 1,1,0,0; check_cnt = 3; err_cnt = 0; mismatch never asserted.
- After s/r = 10, force q = 0 at the next edge. Required: mismatch pulses one cycle, err_cnt = 1, err_sticky = 1 and stays 1 through later correct cycles.
- Drive s/r = 11 twice, then 00, with q arbitrary. Required: forbidden_cnt = 2, ref_valid = 0, check_cnt unchanged. Then drive 01: ref_valid = 1 next cycle and checking resumes.
- Hold s/r = 10 with q = 1 and qbar = 1 for 3 edges. Required: 3 mismatch pulses (complement rule); err_cnt = 3.
- With CNT_W = 4, apply 20 forbidden edges. Required: forbidden_cnt saturates at 15 with no wrap. Then assert clr: all counters = 0, err_sticky = 0, ref_valid = 0.
- Assert rst_n low mid-run between edges. Required: outputs go to reset values immediately, without waiting for clk. With en = 0 for 5 edges, state and counters stay frozen.

Source files
------------

// File: rtl/sr_ff_checker_if.sv
// Bundles the stimulus, observed flip-flop response and checker results of sr_ff_checker.
// The master side drives the flip-flop stimulus/response; the slave side is the checker.
interface sr_ff_checker_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             clr;
  logic             s;
  logic             r;
  logic             q;
  logic             qbar;
  logic             q_ref;
  logic             ref_valid;
  logic             mismatch;
  logic             err_sticky;
  logic [CNT_W-1:0] forbidden_cnt;
  logic [CNT_W-1:0] check_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output en, clr, s, r, q, qbar,
    input  q_ref, ref_valid, mismatch, err_sticky, forbidden_cnt, check_cnt, err_cnt
  );

  modport slave (
    input  en, clr, s, r, q, qbar,
    output q_ref, ref_valid, mismatch, err_sticky, forbidden_cnt, check_cnt, err_cnt
  );
endinterface

// File: rtl/sr_ff_checker.sv
// Cycle-by-cycle checker for a clocked SR flip-flop: tracks a reference Q, flags Q/Qbar
// errors and forbidden S=R=1 inputs, and keeps saturating event counters.
module sr_ff_checker #(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  sr_ff_checker_if.slave bus
);

  typedef enum logic [0:0] {
    ST_UNK   = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_q_ref;
  logic             w_q_ref_nxt;
  logic             r_mismatch;
  logic             w_mismatch_nxt;
  logic             r_err_sticky;
  logic             w_err_sticky_nxt;
  logic [CNT_W-1:0] r_forbidden_cnt;
  logic [CNT_W-1:0] w_forbidden_cnt_nxt;
  logic [CNT_W-1:0] r_check_cnt;
  logic [CNT_W-1:0] w_check_cnt_nxt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] w_err_cnt_nxt;
  logic             w_fail;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // State, reference model and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_UNK;
      r_q_ref         <= 1'b0;
      r_mismatch      <= 1'b0;
      r_err_sticky    <= 1'b0;
      r_forbidden_cnt <= {CNT_W{1'b0}};
      r_check_cnt     <= {CNT_W{1'b0}};
      r_err_cnt       <= {CNT_W{1'b0}};
    end else begin
      r_state         <= w_state_nxt;
      r_q_ref         <= w_q_ref_nxt;
      r_mismatch      <= w_mismatch_nxt;
      r_err_sticky    <= w_err_sticky_nxt;
      r_forbidden_cnt <= w_forbidden_cnt_nxt;
      r_check_cnt     <= w_check_cnt_nxt;
      r_err_cnt       <= w_err_cnt_nxt;
    end
  end

  // Next state: check against the current reference first, then update it from s/r
  always_comb begin
    w_state_nxt         = r_state;
    w_q_ref_nxt         = r_q_ref;
    w_mismatch_nxt      = 1'b0;
    w_err_sticky_nxt    = r_err_sticky;
    w_forbidden_cnt_nxt = r_forbidden_cnt;
    w_check_cnt_nxt     = r_check_cnt;
    w_err_cnt_nxt       = r_err_cnt;
    w_fail              = 1'b0;

    if (bus.clr) begin
      w_state_nxt         = ST_UNK;
      w_q_ref_nxt         = 1'b0;
      w_err_sticky_nxt    = 1'b0;
      w_forbidden_cnt_nxt = {CNT_W{1'b0}};
      w_check_cnt_nxt     = {CNT_W{1'b0}};
      w_err_cnt_nxt       = {CNT_W{1'b0}};
    end else if (bus.en) begin
      if (r_state == ST_TRACK) begin
        w_fail          = (bus.q != r_q_ref) || (bus.qbar != ~bus.q);
        w_check_cnt_nxt = sat_inc(r_check_cnt);
        if (w_fail) begin
          w_err_cnt_nxt    = sat_inc(r_err_cnt);
          w_err_sticky_nxt = 1'b1;
          w_mismatch_nxt   = 1'b1;
        end else begin
          w_err_cnt_nxt    = r_err_cnt;
          w_err_sticky_nxt = r_err_sticky;
          w_mismatch_nxt   = 1'b0;
        end
      end else begin
        w_check_cnt_nxt = r_check_cnt;
      end

      // q_ref is left untouched on 11: it is meaningless while UNK
      case ({bus.s, bus.r})
        2'b00: begin
          w_state_nxt = r_state;
        end
        2'b01: begin
          w_q_ref_nxt = 1'b0;
          w_state_nxt = ST_TRACK;
        end
        2'b10: begin
          w_q_ref_nxt = 1'b1;
          w_state_nxt = ST_TRACK;
        end
        2'b11: begin
          w_forbidden_cnt_nxt = sat_inc(r_forbidden_cnt);
          w_state_nxt         = ST_UNK;
        end
        default: begin
          w_state_nxt = ST_UNK;
        end
      endcase
    end else begin
      w_mismatch_nxt = 1'b0;
    end
  end

  assign bus.q_ref         = r_q_ref;
  assign bus.ref_valid     = (r_state == ST_TRACK);
  assign bus.mismatch      = r_mismatch;
  assign bus.err_sticky    = r_err_sticky;
  assign bus.forbidden_cnt = r_forbidden_cnt;
  assign bus.check_cnt     = r_check_cnt;
  assign bus.err_cnt       = r_err_cnt;

endmodule
